adder_req_arbiter: RTL
======================

// Module: adder_req_arbiter
// PURPOSE
//  Shares one adder/ALU instance (ports a, b, opcode -> c) among NUM_REQ requesters.
//  Round-robin arbitration picks one request. The block drives the ALU operands and waits the
//  ALU pipeline latency. It then returns the result, tagged with the requester index,
//  over a valid/ready response channel. Sits between requester blocks and the adder DUT.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..16)
//  DATA_W   4   operand width (matches adder a/b)
//  OP_W     2   opcode width (matches adder opcode)
//  RES_W    5   result width (matches adder c; DATA_W+1)
//  ADD_LAT  1   adder register stages between a/b/opcode and c (0 = combinational)
//  ID_W     2   requester id width, $clog2(NUM_REQ)
// PORTS
//  clk         in   1              clock, all logic on posedge
//  reset       in   1              synchronous, active-high
//  req         in   NUM_REQ        per-requester request level
//  req_a       in   NUM_REQ*DATA_W packed operand a, slice i for requester i
//  req_b       in   NUM_REQ*DATA_W packed operand b
//  req_op      in   NUM_REQ*OP_W   packed opcode
//  gnt         out  NUM_REQ        one-hot, one-cycle grant pulse
//  rsp_valid   out  1              response valid
//  rsp_ready   in   1              response accepted
//  rsp_id      out  ID_W           index of requester owning rsp_data
//  rsp_data    out  RES_W          captured adder result
//  alu_a       out  DATA_W         to adder a
//  alu_b       out  DATA_W         to adder b
//  alu_opcode  out  OP_W           to adder opcode
//  alu_c       in   RES_W          from adder c
//  busy        out  1              high whenever state != IDLE
// BEHAVIOUR
//  Reset: synchronous, active-high, applied at the posedge. State goes to IDLE.
//   gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, alu_a/alu_b/alu_opcode=0, cnt=0, ptr=NUM_REQ-1.
//   Reset mid-operation discards the in-flight op: no response is produced.
//  FSM IDLE -> WAIT -> RESP -> IDLE; all outputs registered.
//  IDLE: req is sampled only here. If any req bit is set at edge E0:
//   - winner = first set bit searching ptr+1, ptr+2, ... mod NUM_REQ.
//   - alu_a/b/opcode <= winner's slices; gnt[winner]=1 for the single cycle after E0.
//   - rsp_id <= winner, ptr <= winner, cnt <= ADD_LAT, state -> WAIT.
//   If no req bit is set, stay in IDLE with gnt=0.
//  WAIT: if cnt==0, capture rsp_data <= alu_c, set rsp_valid=1, go to RESP. Otherwise cnt--.
//   Result is therefore captured at edge E0+ADD_LAT+1.
//  RESP: hold rsp_valid, rsp_id and rsp_data stable until rsp_valid && rsp_ready at an edge.
//   That edge clears rsp_valid and returns to IDLE. Earliest next grant is the following edge.
//   Minimum issue period = ADD_LAT+3 cycles.
//  alu_a/b/opcode hold their value from issue until the next issue; they never glitch mid-op.
//  Requesters:
//   - must hold operands stable while req=1;
//   - must drop req in the gnt cycle, or it is taken as a new request;
//   - may drop req before being granted; that request is then silently withdrawn.
//  Reqs arriving during WAIT/RESP are not lost: they are seen at the next IDLE.
//  rsp_ready is ignored outside RESP. Arithmetic is entirely in the adder; no width change here.
// TESTING
//  1. Reset, req=4'b0001, a0=3, b0=5, op0=0, ADD_LAT=1 ->
//     gnt=0001 one cycle after E0; alu_a=3, alu_b=5;
//     rsp_valid at E0+2 with rsp_id=0, rsp_data=adder(3,5,0)=8.
//  2. req=4'b1111 held, rsp_ready=1, requests re-raised after service ->
//     grant order 0,1,2,3,0; each grant exactly ADD_LAT+3 cycles apart.
//  3. req=4'b0101, rsp_ready=0 for 5 cycles ->
//     rsp_valid and rsp_data stable across all 5 cycles; gnt[2] only after the handshake.
//  4. req[1] asserted during WAIT of requester 3's op ->
//     requester 1 granted at the first IDLE edge after requester 3's handshake; nothing dropped.
//  5. reset pulsed one cycle while in WAIT ->
//     next cycle IDLE, rsp_valid=0, alu_a=0, ptr=NUM_REQ-1; next req=1111 grants requester 0.
//  6. Fully loaded operands a=15, b=15, opcode=0 -> rsp_data=30 (RES_W carry kept).
//     req[2] raised then dropped before being granted -> no gnt[2], no response.

Source files
------------

// File: rtl/adder_req_arbiter.sv
// Round-robin arbiter sharing one pipelined adder/ALU among NUM_REQ requesters.
// Issues the winner's operands, waits out the ALU latency, and returns a tagged result over valid/ready.
module adder_req_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned OP_W    = 2,
  parameter int unsigned RES_W   = 5,
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [RES_W-1:0]          rsp_data,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_opcode,
  input  logic [RES_W-1:0]          alu_c,
  output logic                      busy
);

  localparam int unsigned CNT_W = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [ID_W-1:0]     ptr, ptr_d;
  logic [ID_W-1:0]     winner;
  logic                any_req;
  logic [NUM_REQ-1:0]  gnt_d;
  logic                rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_d;
  logic [RES_W-1:0]    rsp_data_d;
  logic [DATA_W-1:0]   alu_a_d, alu_b_d;
  logic [OP_W-1:0]     alu_opcode_d;

  logic [DATA_W-1:0]   a_arr  [NUM_REQ];
  logic [DATA_W-1:0]   b_arr  [NUM_REQ];
  logic [OP_W-1:0]     op_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]  = req_a[g*DATA_W +: DATA_W];
    assign b_arr[g]  = req_b[g*DATA_W +: DATA_W];
    assign op_arr[g] = req_op[g*OP_W +: OP_W];
  end

  // First set request after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx_full;
    logic [ID_W-1:0] idx;
    winner   = ptr;
    any_req  = 1'b0;
    idx_full = 0;
    idx      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx_full = (32'(ptr) + k) % NUM_REQ;
      idx      = ID_W'(idx_full);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (any_req)      next_state = S_WAIT;
      S_WAIT:  if (cnt == '0)    next_state = S_RESP;
      S_RESP:  if (rsp_ready)    next_state = S_IDLE;
      default:                   next_state = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping.
  always_comb begin
    gnt_d        = '0;
    rsp_valid_d  = rsp_valid;
    rsp_id_d     = rsp_id;
    rsp_data_d   = rsp_data;
    alu_a_d      = alu_a;
    alu_b_d      = alu_b;
    alu_opcode_d = alu_opcode;
    cnt_d        = cnt;
    ptr_d        = ptr;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          gnt_d        = NUM_REQ'(1) << winner;
          alu_a_d      = a_arr[winner];
          alu_b_d      = b_arr[winner];
          alu_opcode_d = op_arr[winner];
          rsp_id_d     = winner;
          ptr_d        = winner;
          cnt_d        = CNT_W'(ADD_LAT);
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          rsp_data_d  = alu_c;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      cnt        <= '0;
      ptr        <= ID_W'(NUM_REQ - 1);
      busy       <= 1'b0;
    end else begin
      gnt        <= gnt_d;
      rsp_valid  <= rsp_valid_d;
      rsp_id     <= rsp_id_d;
      rsp_data   <= rsp_data_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      alu_opcode <= alu_opcode_d;
      cnt        <= cnt_d;
      ptr        <= ptr_d;
      busy       <= (next_state != S_IDLE);
    end
  end

endmodule
